// File: rtl/debounce_pkg.sv
// Shared defaults and the threshold clamp for the multi-channel debouncer.
// Optional macro DEBOUNCE_NCH_EDGE_EN (used by debounce_ch) enables the rise/fall edge flops.
package debounce_pkg;

    localparam int DEF_CH          = 4;
    localparam int DEF_CNT_W       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // A zero threshold behaves as one so a channel can never lock up.
    function automatic int unsigned eff_thresh(input int unsigned thresh);
        return (thresh == 0) ? 32'd1 : thresh;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: input synchroniser, stability counter, debounced level flop.
// Rise/fall pulse flops exist only when DEBOUNCE_NCH_EDGE_EN is defined; otherwise both are tied to 0.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   CNT_W       = DEF_CNT_W,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_i,
    input  logic [CNT_W-1:0] thresh,
    output logic             out_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       last_cnt;
    logic                   out_q, out_d;
    logic                   s;
    logic                   flip;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], in_i};
        s        = sync_q[SYNC_STAGES-1];
        last_cnt = CNT_W'(eff_thresh(32'(thresh)) - 32'd1);
        flip     = 1'b0;
        cnt_d    = '0;
        // >= lets a lowered threshold take effect on a count already past it.
        if (s != out_q) begin
            if (cnt_q >= last_cnt) begin
                flip = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        out_d = flip ? s : out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            cnt_q  <= '0;
            out_q  <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign out_o = out_q;

`ifdef DEBOUNCE_NCH_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Pulses register alongside out_q so they appear in the same cycle as the new level.
    always_comb begin
        rise_d = flip & s;
        fall_d = flip & ~s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_nch.sv
// CH independent debounce channels sharing one threshold input.
// Macro DEBOUNCE_NCH_EDGE_EN enables the rise/fall pulse outputs (tied to 0 when undefined).
module debounce_nch
    import debounce_pkg::*;
#(
    parameter int   CH          = DEF_CH,
    parameter int   CNT_W       = DEF_CNT_W,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    in,
    input  logic [CNT_W-1:0] thresh,
    output logic [CH-1:0]    out,
    output logic [CH-1:0]    rise,
    output logic [CH-1:0]    fall
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_ch #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .RST_VAL    (RST_VAL)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .in_i  (in[i]),
            .thresh(thresh),
            .out_o (out[i]),
            .rise_o(rise[i]),
            .fall_o(fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_nch.sv
// Directed bench for debounce_nch (CH=4, SYNC_STAGES=2, RST_VAL=0).
// Edge k is the k-th rising clock edge after the stimulus for that scenario starts.
module tb_debounce_nch;

    localparam int CH    = 4;
    localparam int CNT_W = 4;
`ifdef DEBOUNCE_NCH_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    din = '0;
    logic [CNT_W-1:0] thresh = 4'd3;
    logic [CH-1:0]    out, rise, fall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debounce_nch #(
        .CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(2), .RST_VAL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(din), .thresh(thresh),
        .out(out), .rise(rise), .fall(fall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [CH-1:0] din_v, input logic [CNT_W-1:0] th);
        rst_n  = 1'b0;
        din    = din_v;
        thresh = th;
        repeat (3) tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [CH-1:0] exp_out, exp_rise;
        rst_n  = 1'b0;
        din    = 4'hF;
        thresh = 4'd3;
        repeat (3) tick;
        checks++; if (out !== 4'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", out); end
        checks++; if (rise !== 4'h0) begin failures++; $display("FAIL reset_rise got=%h exp=0", rise); end
        checks++; if (fall !== 4'h0) begin failures++; $display("FAIL reset_fall got=%h exp=0", fall); end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick;
            exp_out  = (k >= 5) ? 4'hF : 4'h0;
            exp_rise = (EDGE_EN && k == 5) ? 4'hF : 4'h0;
            checks++; if (out !== exp_out) begin failures++; $display("FAIL first_out edge=%0d got=%h exp=%h", k, out, exp_out); end
            checks++; if (rise !== exp_rise) begin failures++; $display("FAIL first_rise edge=%0d got=%h exp=%h", k, rise, exp_rise); end
            checks++; if (fall !== 4'h0) begin failures++; $display("FAIL first_fall edge=%0d got=%h exp=0", k, fall); end
        end
    endtask

    task automatic test_glitch;
        logic e_out, e_rise, e_fall;
        do_reset(4'h0, 4'd3);
        for (int k = 1; k <= 12; k++) begin
            din[0] = (k <= 2);
            tick;
            checks++; if (out[0] !== 1'b0) begin failures++; $display("FAIL glitch2_out edge=%0d got=%b exp=0", k, out[0]); end
            checks++; if (rise[0] !== 1'b0 || fall[0] !== 1'b0) begin
                failures++; $display("FAIL glitch2_edge edge=%0d rise=%b fall=%b exp=0/0", k, rise[0], fall[0]);
            end
        end
        do_reset(4'h0, 4'd3);
        for (int k = 1; k <= 12; k++) begin
            din[0] = (k <= 3);
            tick;
            e_out  = (k >= 5 && k <= 7);
            e_rise = EDGE_EN && (k == 5);
            e_fall = EDGE_EN && (k == 8);
            checks++; if (out[0] !== e_out) begin failures++; $display("FAIL pulse3_out edge=%0d got=%b exp=%b", k, out[0], e_out); end
            checks++; if (rise[0] !== e_rise) begin failures++; $display("FAIL pulse3_rise edge=%0d got=%b exp=%b", k, rise[0], e_rise); end
            checks++; if (fall[0] !== e_fall) begin failures++; $display("FAIL pulse3_fall edge=%0d got=%b exp=%b", k, fall[0], e_fall); end
        end
        din = '0;
    endtask

    task automatic test_independence;
        logic [CH-1:0] exp_out, exp_rise;
        do_reset(4'h0, 4'd3);
        for (int k = 1; k <= 12; k++) begin
            din = 4'b0101 | ((k % 2 == 1) ? 4'b0010 : 4'b0000);
            tick;
            exp_out  = (k >= 5) ? 4'b0101 : 4'b0000;
            exp_rise = (EDGE_EN && k == 5) ? 4'b0101 : 4'b0000;
            checks++; if (out !== exp_out) begin failures++; $display("FAIL indep_out edge=%0d got=%b exp=%b", k, out, exp_out); end
            checks++; if (rise !== exp_rise) begin failures++; $display("FAIL indep_rise edge=%0d got=%b exp=%b", k, rise, exp_rise); end
        end
        din = '0;
    endtask

    task automatic test_thresh_change;
        do_reset(4'h0, 4'd8);
        din = 4'b0100;
        for (int k = 1; k <= 7; k++) begin
            tick;
            checks++; if (out[2] !== 1'b0) begin failures++; $display("FAIL thchg_hold edge=%0d got=%b exp=0", k, out[2]); end
        end
        thresh = 4'd2;
        tick;
        checks++; if (out[2] !== 1'b1) begin failures++; $display("FAIL thchg_flip got=%b exp=1", out[2]); end
        checks++; if (rise[2] !== EDGE_EN) begin failures++; $display("FAIL thchg_rise got=%b exp=%b", rise[2], EDGE_EN); end
        din = '0;
    endtask

    task automatic test_reset_mid;
        do_reset(4'h0, 4'd3);
        din = 4'b1000;
        repeat (5) tick;
        checks++; if (out[3] !== 1'b1) begin failures++; $display("FAIL rstmid_setup got=%b exp=1", out[3]); end
        din = 4'b0000;
        for (int k = 6; k <= 9; k++) begin
            tick;
            checks++; if (out[3] !== 1'b1 || fall[3] !== 1'b0) begin
                failures++; $display("FAIL rstmid_count edge=%0d out=%b fall=%b exp=1/0", k, out[3], fall[3]);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++; if (out[3] !== 1'b0) begin failures++; $display("FAIL rstmid_out got=%b exp=0", out[3]); end
        checks++; if (fall[3] !== 1'b0) begin failures++; $display("FAIL rstmid_fall got=%b exp=0", fall[3]); end
        din = 4'b1000;
        repeat (2) begin
            tick;
            checks++; if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
                failures++; $display("FAIL rstmid_held out=%h rise=%h fall=%h exp=0/0/0", out, rise, fall);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            checks++; if (out[3] !== (k >= 5)) begin failures++; $display("FAIL rstmid_recount edge=%0d got=%b exp=%b", k, out[3], (k >= 5)); end
            checks++; if (fall[3] !== 1'b0) begin failures++; $display("FAIL rstmid_nofall edge=%0d got=%b exp=0", k, fall[3]); end
        end
        din = '0;
    endtask

    task automatic test_thresh_zero;
        logic hist [0:15];
        logic e_out, prev_out, e_rise;
        do_reset(4'h0, 4'd0);
        prev_out = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            hist[k] = (k <= 6) ? ((k % 2) == 1) : 1'b1;
            din[0]  = hist[k];
            tick;
            e_out  = (k >= 3) ? hist[k-2] : 1'b0;
            e_rise = EDGE_EN && e_out && !prev_out;
            checks++; if (out[0] !== e_out) begin failures++; $display("FAIL th0_out edge=%0d got=%b exp=%b", k, out[0], e_out); end
            checks++; if (rise[0] !== e_rise) begin failures++; $display("FAIL th0_rise edge=%0d got=%b exp=%b", k, rise[0], e_rise); end
            prev_out = e_out;
        end
        din = '0;
    endtask

    task automatic test_max_thresh;
        do_reset(4'h0, 4'd15);
        din = 4'b0010;
        for (int k = 1; k <= 18; k++) begin
            tick;
            checks++; if (out[1] !== (k >= 17)) begin failures++; $display("FAIL maxth_out edge=%0d got=%b exp=%b", k, out[1], (k >= 17)); end
        end
        din = '0;
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_independence;
        test_thresh_change;
        test_reset_mid;
        test_thresh_zero;
        test_max_thresh;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_nch.md
DEBOUNCE_NCH -- requirements
Module: debounce_nch

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent debounce channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 4: width of the per-channel stability counter and of thresh.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth (2..4).
REQ-004 SHALL have parameter RST_VAL, default 1'b0: reset value of every out bit and every synchroniser flop.
REQ-005 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port in, input, CH: raw asynchronous inputs, one bit per channel.
REQ-008 SHALL have port thresh, input, CNT_W: required stable-cycle count, common to all channels, sampled every cycle.
REQ-009 SHALL have port out, output, CH: debounced level per channel.
REQ-010 SHALL have port rise, output, CH: one-cycle pulse per channel on each out 0->1 transition.
REQ-011 SHALL have port fall, output, CH: one-cycle pulse per channel on each out 1->0 transition.

Function
REQ-012 SHALL pass each in bit through a SYNC_STAGES-deep flop chain; the last stage is s[i].
REQ-013 SHALL clear cnt[i] to 0 on each cycle where s[i] == out[i].
REQ-014 SHALL, on each cycle where s[i] != out[i], set out[i] <= s[i] and cnt[i] <= 0 if cnt[i] >= eff_thresh-1; otherwise cnt[i] <= cnt[i]+1.
REQ-015 SHALL use eff_thresh = 1 when thresh == 0, else eff_thresh = thresh.
REQ-016 SHALL make out[i] follow a level held stable on in[i] exactly SYNC_STAGES + eff_thresh clock edges after that level is first sampled.
REQ-017 SHALL suppress any pulse of either polarity lasting fewer than eff_thresh cycles at s[i]: no change on out[i], rise[i] or fall[i].
REQ-018 SHALL use >= in the REQ-014 compare, so that lowering thresh below a running cnt[i] flips out[i] on the next edge.
REQ-019 SHALL register rise[i] and fall[i], asserting them for exactly one cycle, in the same cycle out[i] shows its new value.
REQ-020 SHALL never increment cnt[i] past eff_thresh-1 (no wrap-around), including with thresh = 2^CNT_W-1.
REQ-021 SHALL keep all channels fully independent: no shared counter and no cross-channel dependency.

Reset
REQ-022 SHALL, while rst_n is low, force out = {CH{RST_VAL}}, rise = 0, fall = 0, all cnt = 0, and all synchroniser flops = RST_VAL.
REQ-023 SHALL, when rst_n is asserted in the middle of a count, abort the count without producing a rise or fall pulse.
REQ-024 SHALL release reset synchronously; the first count starts on the first clk edge with rst_n high.

Configuration
REQ-025 SHALL generate rise/fall logic when macro DEBOUNCE_NCH_EDGE_EN is defined.
REQ-026 SHALL, when DEBOUNCE_NCH_EDGE_EN is undefined, tie rise and fall to constant 0 and omit their flops, keeping the port list unchanged.

Structure
REQ-027 SHALL place the default values of CH, CNT_W and SYNC_STAGES, and the eff_thresh clamp rule as a constant or function, in shared package debounce_pkg.
REQ-028 SHALL implement one channel (synchroniser, counter, out/edge flops) in sub-module debounce_ch, instantiated CH times in a generate loop.

Verification
All scenarios use CH=4, SYNC_STAGES=2, RST_VAL=0, thresh=3, edges numbered from the first edge after rst_n deasserts.
REQ-029 SHALL cover reset and first transition: in=4'hF during and after reset -> out=0 during reset; out=4'hF at edge 5; rise=4'hF for one cycle only; fall=0 throughout.
REQ-030 SHALL cover glitch rejection: in[0] high for 2 cycles, else low -> out[0], rise[0] and fall[0] stay 0; a 3-cycle high pulse -> out[0] high for 3 cycles, with one rise and one fall pulse.
REQ-031 SHALL cover channel independence: in=4'b0101 steady, in[1] toggling every cycle -> out=4'b0101 after 5 edges, out[1] never changes.
REQ-032 SHALL cover a threshold change mid-count: thresh=8, in[2] rises, then thresh set to 2 while cnt[2]=5 -> out[2]=1 on the next edge.
REQ-033 SHALL cover reset during a count: rst_n low while cnt[3]=2 and out[3]=1 -> out[3]=0 immediately, fall[3] stays 0, cnt[3]=0.
REQ-034 SHALL cover thresh=0: in[0] toggles, then holds -> behaves as thresh=1, out[0] following at 3 edges.
